mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle processor's memory bus. It accepts read and write requests driven by the processor control unit. It services them from an internal word-addressed data RAM or one memory-mapped I/O register, inserting a fixed number of wait states. It signals completion with a one-cycle `MemReady` pulse. It sits between the control unit/datapath address mux and the board I/O.

## Interface
- `DATA_W`, default 8: data word width.
- `ADDR_W`, default 8: address width; RAM depth is 2^ADDR_W words.
- `WAIT_CYCLES`, default 2: wait states per access. Legal range is 0..15 (4-bit counter).
- `IO_ADDR`, default 8'hFF: address decoded as the I/O register instead of RAM.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-low reset. It is sampled on the rising edge of `clock`.
- `MemRead`  in  1: read request level, held by the requester until `MemReady`.
- `MemWrite`  in  1: write request level, held by the requester until `MemReady`.
- `Addr`  in  ADDR_W: request address.
- `WriteData`  in  DATA_W: write data.
- `sw_in`  in  DATA_W: external input read at `IO_ADDR`.
- `ReadData`  out  DATA_W: registered read result; held between reads.
- `MemReady`  out  1: one-cycle completion pulse.
- `io_out`  out  DATA_W: I/O output register, written at `IO_ADDR`.
- `ProtoErr`  out  1: sticky flag; set when `MemRead` and `MemWrite` are both sampled high in IDLE.

## Operation
- FSM states:
  - IDLE (encoding 2'd0)
  - BUSY (2'd1)
  - DONE (2'd2)
  - 2'd3 is illegal and returns to IDLE.
- IDLE:
  - If `MemWrite` or `MemRead` is high at the edge, latch `Addr`, `WriteData` and the operation into request registers.
  - Load the wait counter with WAIT_CYCLES.
  - Next state is BUSY if WAIT_CYCLES > 0, otherwise DONE.
  - With no request, stay in IDLE.
- BUSY:
  - Decrement the counter every edge.
  - When the counter equals 1 at an edge, go to DONE.
  - Request inputs are ignored in BUSY; latched values are used.
- Access commit, on the edge entering DONE:
  - Write to RAM address: `mem[addr_q] <= wdata_q`.
  - Write to `IO_ADDR`: `io_out <= wdata_q`; RAM is untouched.
  - Read from RAM address: `ReadData <= mem[addr_q]`.
  - Read from `IO_ADDR`: `ReadData <= sw_in` sampled at that edge.
- DONE:
  - `MemReady` = 1 for exactly this cycle.
  - Next state is always IDLE; inputs are ignored.
  - A request still high in the following IDLE cycle is a new transaction.
- Simultaneous `MemRead` and `MemWrite` in IDLE:
  - The write wins and a write transaction proceeds.
  - `ProtoErr` sets and stays set until reset.
- RAM contents are not cleared by reset and power up undefined.
- The RAM is a single-port synchronous array with no combinational read path.
- Address arithmetic:
  - No address arithmetic is performed.
  - Out-of-range addresses cannot occur, because depth equals 2^ADDR_W.
  - The counter is 4 bits with no wrap, because a load of 0 bypasses BUSY.

## Timing
- Reset values when `reset` = 0 at an edge:
  - State IDLE, counter 0.
  - `MemReady` 0, `ReadData` 0, `io_out` 0, `ProtoErr` 0.
  - Request registers 0.
- Reset mid-transaction aborts the access: no RAM or `io_out` write occurs and no `MemReady` pulse is produced.
- Latency: request sampled at edge E0 gives `MemReady` high in cycle E0+WAIT_CYCLES+1 (the cycle after edge E0+WAIT_CYCLES). BUSY occupies WAIT_CYCLES cycles.
- Throughput: one access per WAIT_CYCLES+2 cycles. DONE and IDLE each cost one cycle even with back-to-back requests.
- `ReadData` changes only on the edge entering DONE of a read, and is stable while `MemReady` is high.
- A write's data is visible to any read whose request is sampled at or after the write's DONE→IDLE edge.

## Test plan
1. Reset held low 3 cycles with `MemWrite`=1 → all outputs 0, no RAM write. Then read addr 0x10 after preloading it by write 0x5A → `ReadData`=0x5A.
2. WAIT_CYCLES=2: write 0xA5 to 0x03 at E0 → `MemReady` high in cycle 3 only. Then read 0x03 → `ReadData`=0xA5 with `MemReady` 3 cycles after sample.
3. WAIT_CYCLES=0: read request at E0 → `MemReady` in cycle 1. Request held through DONE → second transaction starts in the following IDLE, second `MemReady` at cycle 3.
4. Write 0x3C to 0xFF → `io_out`=0x3C and RAM[0xFF] unchanged. Read 0xFF with `sw_in`=0x81 → `ReadData`=0x81.
5. `MemRead`=`MemWrite`=1, addr 0x20, data 0x77 → write performed and `ProtoErr`=1, remaining 1 after later clean accesses until reset.
6. Reset asserted during BUSY of write 0x99 to 0x40 → no `MemReady`. Subsequent read of 0x40 returns the prior value, not 0x99.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder for the multicycle processor bus.
//                Services held MemRead/MemWrite requests from a word-addressed
//                synchronous RAM or a single memory-mapped I/O register. It
//                inserts WAIT_CYCLES wait states and signals completion with a
//                one-cycle MemReady pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
   parameter int                DATA_W      = 8,
   parameter int                ADDR_W      = 8,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] IO_ADDR     = 8'hFF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [DATA_W-1:0] sw_in,
   output logic [DATA_W-1:0] ReadData,
   output logic              MemReady,
   output logic [DATA_W-1:0] io_out,
   output logic              ProtoErr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                rdy_q, rdy_d;
   logic                perr_q, perr_d;
   logic [DATA_W-1:0]   io_q, io_d;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic                w_req;
   logic                w_commit;
   logic                w_acc_io;

   assign w_req    = MemRead | MemWrite;
   // addr_d/wdata_d/wr_d always hold the access being committed: the live
   // request when WAIT_CYCLES is 0, otherwise the latched request.
   assign w_acc_io = (addr_d == IO_ADDR);

   // Next-state, request latching, commit strobe and I/O register update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      perr_d   = perr_q;
      rdy_d    = 1'b0;
      w_commit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               addr_d  = Addr;
               wdata_d = WriteData;
               wr_d    = MemWrite;            // write wins on a collision
               cnt_d   = c_wait_load;
               if (MemRead && MemWrite) begin
                  perr_d = 1'b1;
               end
               if (c_wait_load == 4'd0) begin
                  state_d  = S_DONE;
                  w_commit = 1'b1;
                  rdy_d    = 1'b1;
               end else begin
                  state_d  = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d  = S_DONE;
               w_commit = 1'b1;
               rdy_d    = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      io_d = io_q;
      if (w_commit && wr_d && w_acc_io) begin
         io_d = wdata_d;
      end
   end

   // Control and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rdy_q   <= 1'b0;
         perr_q  <= 1'b0;
         io_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         rdy_q   <= rdy_d;
         perr_q  <= perr_d;
         io_q    <= io_d;
      end
   end

   // RAM write port; reset blocks the write so an aborted access never lands
   always_ff @(posedge clock) begin
      if (reset && w_commit && wr_d && !w_acc_io) begin
         mem[addr_d] <= wdata_d;
      end
   end

   // Registered read result, updated only on the edge entering DONE of a read
   always_ff @(posedge clock) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (w_commit && !wr_d) begin
         rdata_q <= w_acc_io ? sw_in : mem[addr_d];
      end
   end

   assign ReadData = rdata_q;
   assign MemReady = rdy_q;
   assign io_out   = io_q;
   assign ProtoErr = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Scoreboard bench for mem_responder (WAIT_CYCLES=2 main
//                instance, WAIT_CYCLES=0 instance for zero-wait timing).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

   localparam int W = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_read, mem_write;
   logic [7:0] addr, wdata, sw;
   logic [7:0] rdata, io;
   logic       ready, perr;

   logic       mem_read0, mem_write0;
   logic [7:0] addr0, wdata0, sw0;
   logic [7:0] rdata0, io0;
   logic       ready0, perr0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(W), .IO_ADDR(8'hFF)) dut (
      .clock(clk), .reset(rst_n), .MemRead(mem_read), .MemWrite(mem_write),
      .Addr(addr), .WriteData(wdata), .sw_in(sw), .ReadData(rdata),
      .MemReady(ready), .io_out(io), .ProtoErr(perr)
   );

   mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0), .IO_ADDR(8'hFF)) dut0 (
      .clock(clk), .reset(rst_n), .MemRead(mem_read0), .MemWrite(mem_write0),
      .Addr(addr0), .WriteData(wdata0), .sw_in(sw0), .ReadData(rdata0),
      .MemReady(ready0), .io_out(io0), .ProtoErr(perr0)
   );

   // Reference model: memory contents, I/O register, last read value, sticky error
   logic [7:0] ref_mem [256];
   logic [7:0] m_io, m_rd;
   logic       m_perr;

   typedef struct {
      logic [7:0] rd;
      logic [7:0] io;
      logic       perr;
      int         due;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one transaction at a negedge in IDLE, hold it until MemReady, then return to IDLE
   task automatic xact(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] s);
      exp_t e;
      bit   got;
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      wdata     = d;
      sw        = s;
      if (rd && wr) m_perr = 1'b1;
      if (wr) begin
         if (a == 8'hFF) m_io = d;
         else            ref_mem[a] = d;
      end else begin
         m_rd = (a == 8'hFF) ? s : ref_mem[a];
      end
      e.rd   = m_rd;
      e.io   = m_io;
      e.perr = m_perr;
      e.due  = cyc + 1 + W;
      sbq.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (ready) got = 1'b1;
      end
      chk("ready_seen", {31'd0, got}, 32'd1);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_MemReady"}, {31'd0, ready}, 32'd0);
      chk({tag, "_ReadData"}, {24'd0, rdata}, 32'd0);
      chk({tag, "_io_out"},   {24'd0, io},    32'd0);
      chk({tag, "_ProtoErr"}, {31'd0, perr},  32'd0);
   endtask

   // Monitor: every MemReady pulse must match the oldest outstanding expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (ready === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: MemReady=1 with nothing pending, expected 0 (cycle %0d)", cyc);
         end else begin
            e = sbq.pop_front();
            chk("latency_cycle", cyc,             e.due);
            chk("ReadData",      {24'd0, rdata},  {24'd0, e.rd});
            chk("io_out",        {24'd0, io},     {24'd0, e.io});
            chk("ProtoErr",      {31'd0, perr},   {31'd0, e.perr});
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] a;
      int         op;
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b1; addr = 8'h10; wdata = 8'hEE; sw = 8'h00;
      mem_read0 = 1'b0; mem_write0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00; sw0 = 8'h00;
      m_io = 8'h00; m_rd = 8'h00; m_perr = 1'b0;

      // Reset held for three cycles with a write pending
      repeat (3) begin
         @(negedge clk);
         chk_reset_outputs("reset");
         chk("reset_w0_MemReady", {31'd0, ready0}, 32'd0);
      end
      rst_n = 1'b1; mem_write = 1'b0;
      @(negedge clk);

      // Directed accesses
      xact(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00);
      xact(1'b1, 1'b0, 8'h10, 8'h00, 8'h00);
      xact(1'b0, 1'b1, 8'h03, 8'hA5, 8'h00);
      xact(1'b1, 1'b0, 8'h03, 8'h00, 8'h00);
      xact(1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00);
      xact(1'b1, 1'b0, 8'hFF, 8'h00, 8'h81);

      // Define every RAM word
      for (int i = 0; i < 255; i++) xact(1'b0, 1'b1, 8'(i), 8'($urandom), 8'($urandom));

      // Random clean traffic
      for (int n = 0; n < 150; n++) begin
         a  = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         op = $urandom_range(0, 1);
         xact(op == 0, op == 1, a, 8'($urandom), 8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Collision: write wins, error becomes sticky
      xact(1'b1, 1'b1, 8'h20, 8'h77, 8'h00);
      xact(1'b1, 1'b0, 8'h20, 8'h00, 8'h00);
      for (int n = 0; n < 80; n++) begin
         a  = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         op = $urandom_range(0, 9);
         xact(op != 1, op != 0, a, 8'($urandom), 8'($urandom));
      end

      // Reset during BUSY of a write aborts it
      mem_write = 1'b1; addr = 8'h40; wdata = 8'h99;
      @(negedge clk);
      rst_n = 1'b0; mem_write = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("abort");
      rst_n = 1'b1;
      m_io = 8'h00; m_rd = 8'h00; m_perr = 1'b0;
      @(negedge clk);
      xact(1'b1, 1'b0, 8'h40, 8'h00, 8'h00);
      xact(1'b0, 1'b1, 8'hFF, 8'hC3, 8'h00);

      // Zero-wait instance: held read repeats every second cycle
      mem_read0 = 1'b1; addr0 = 8'hFF; sw0 = 8'h42;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("w0_ready_pattern", {31'd0, ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
         if (k == 0) chk("w0_io_read", {24'd0, rdata0}, 32'h42);
      end
      mem_read0 = 1'b0;
      @(negedge clk);
      mem_write0 = 1'b1; addr0 = 8'h07; wdata0 = 8'h6B;
      @(negedge clk);
      chk("w0_write_ready", {31'd0, ready0}, 32'd1);
      mem_write0 = 1'b0; mem_read0 = 1'b1;
      @(negedge clk);
      chk("w0_done_to_idle", {31'd0, ready0}, 32'd0);
      @(negedge clk);
      chk("w0_read_ready", {31'd0, ready0}, 32'd1);
      chk("w0_read_data",  {24'd0, rdata0}, 32'h6B);
      chk("w0_io_untouched", {24'd0, io0},  32'h00);
      chk("w0_ProtoErr",   {31'd0, perr0},  32'd0);
      mem_read0 = 1'b0;
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
